trig_stim_gen: RTL and testbench
================================

# trig_stim_gen

Plaintext stimulus generator that drives the hardware-trojan trigger path from the transmit side. It emits a programmable burst of 64-bit plaintext blocks over a valid/ready stream. Exactly one selectable block carries the 32-bit trigger pattern scattered onto the tap bit positions; every other block carries a one-bit near-miss of that pattern. It sits in the Chipscope example between the host/VIO control and the cipher plaintext input, and exercises the trigger comparator in-system.

## Interface
- TRIG_PATTERN, 32'h331D58BA: trigger value; tap k receives pattern bit k (k=0 is LSB).
- LFSR_SEED, 64'hACE1_0000_0000_0001: fill-LFSR reset seed; must be non-zero.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_blocks  in  8  blocks in the burst, captured at start; 0 means an empty burst.
- trig_idx  in  8  0-based index of the trigger block, captured at start; a value ≥ num_blocks means no trigger block.
- base_pt  in  64  background plaintext for non-tap bits, sampled at each block generation.
- pt_data  out  64  plaintext block.
- pt_valid  out  1  pt_data valid.
- pt_ready  in  1  sink accepts when pt_valid && pt_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst end.
- trig_sent  out  1  sticky; set when the trigger block is accepted, cleared by the next accepted start.

## Operation
- Tap map, with tap k mapped to plaintext bit P[k] for k=0..31: 0,1,3,6,7,9,11,13,14,15,19,20,22,23,26,29,30,32,35,36,38,39,41,45,47,49,50,52,55,58,59,61.
- Block composition:
  - Non-tap bits come from base_pt, or from the LFSR (see Configuration).
  - Tap bits carry TRIG_PATTERN when block index == trig_idx.
  - Otherwise tap bits carry TRIG_PATTERN ^ 32'h1, so tap 0 is inverted and the block never matches.
- The block index counter is 8 bits, cleared at start, and increments on each accept.
- FSM states:
  - IDLE: on start with num_blocks≠0, capture the inputs and go to SEND. On start with num_blocks=0, go to FIN.
  - SEND: pt_valid=1. On accept, if index+1 == num_blocks go to FIN. Otherwise build the next block and stay in SEND.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SEND and FIN. Captured num_blocks and trig_idx are not affected by input changes mid-burst.
- pt_data and pt_valid hold stable while pt_valid && !pt_ready.
- Reset values (any state, including mid-burst): state IDLE, pt_valid 0, pt_data 0, busy 0, done 0, trig_sent 0, index 0, LFSR = LFSR_SEED. The burst is abandoned with no done pulse.

## Timing
- start accepted in cycle N:
  - pt_valid=1 and busy=1 in cycle N+1.
  - For num_blocks=0: busy stays 0, and done pulses in cycle N+1.
- Back-to-back throughput: with pt_ready held at 1, one block per cycle and no bubbles.
- The last accept in cycle M gives pt_valid=0 and done=1 in cycle M+1, with busy falling to 0 in the same cycle.
- trig_sent rises in the cycle after the trigger block is accepted.
- A start arriving in the same cycle as done is ignored. The earliest new start is sampled the cycle after done.

## Configuration
- TRIG_STIM_LFSR_FILL_EN:
  - Defined: non-tap bits come from a 64-bit Fibonacci LFSR (taps 64,63,61,60). The LFSR advances once per accepted block, so every block has fresh filler.
  - Undefined: non-tap bits equal base_pt, and no LFSR is instantiated.
  - Tap bits are identical in both builds.

## Test plan
- Reset, then start with num_blocks=4, trig_idx=2, base_pt=0, pt_ready=1, macro undefined:
  - Four blocks on consecutive cycles.
  - Block 2 tap bits decode to 32'h331D58BA. Blocks 0, 1 and 3 decode to 32'h331D58BB.
  - done rises in the cycle after the 4th accept, and trig_sent=1.
- Hold pt_ready=0 for 5 cycles mid-burst: pt_data and pt_valid are unchanged, no index advance, and the burst completes after pt_ready returns.
- trig_idx=9 with num_blocks=3: three near-miss blocks, trig_sent stays 0, done pulses once.
- num_blocks=0: no pt_valid, done is 1 in the cycle after start, busy never rises.
- Pulse start again in the middle of a 10-block burst: it is ignored. Assert rst_n=0 at block 5: the next cycle shows pt_valid=0, busy=0, done=0, and no done pulse follows.
- Macro defined, base_pt all 1s, num_blocks=3:
  - Non-tap bits differ between consecutive blocks and match the LFSR reference model from LFSR_SEED.
  - Tap bits are identical to the undefined build.

Source files
------------

// File: rtl/trig_stim_gen.sv
// trig_stim_gen: plaintext stimulus generator for the trojan trigger path.
// Emits a burst of num_blocks 64-bit blocks on a valid/ready stream. The
// block at index trig_idx carries TRIG_PATTERN on the 32 tap bit positions;
// every other block carries TRIG_PATTERN ^ 1, a one-bit near miss.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle burst request (honoured only when idle)
//   num_blocks      burst length, captured at start (0 = empty burst)
//   trig_idx        index of the trigger block, captured at start
//   base_pt         background plaintext for non-tap bits
//   pt_data/pt_valid/pt_ready  output block stream
//   busy            burst in progress
//   done            one-cycle pulse at burst end
//   trig_sent       sticky flag: trigger block accepted in this burst
//
// Build option: define TRIG_STIM_LFSR_FILL_EN to fill non-tap bits from a
// 64-bit Fibonacci LFSR (taps 64,63,61,60) instead of base_pt.
module trig_stim_gen #(
  parameter logic [31:0] TRIG_PATTERN = 32'h331D58BA,
  parameter logic [63:0] LFSR_SEED    = 64'hACE1_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  num_blocks,
  input  logic [7:0]  trig_idx,
  input  logic [63:0] base_pt,
  output logic [63:0] pt_data,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic        busy,
  output logic        done,
  output logic        trig_sent
);

  localparam logic [5:0] TAP_POS [32] = '{
    6'd0,  6'd1,  6'd3,  6'd6,  6'd7,  6'd9,  6'd11, 6'd13,
    6'd14, 6'd15, 6'd19, 6'd20, 6'd22, 6'd23, 6'd26, 6'd29,
    6'd30, 6'd32, 6'd35, 6'd36, 6'd38, 6'd39, 6'd41, 6'd45,
    6'd47, 6'd49, 6'd50, 6'd52, 6'd55, 6'd58, 6'd59, 6'd61
  };

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t      state, next_state;
  logic [7:0]  idx, nblk, tidx;
  logic [7:0]  idx_inc;
  logic        accept;
  logic [63:0] fill_now, fill_next;

  // Overlay tap bits onto the filler; hit selects exact pattern vs near miss.
  function automatic logic [63:0] compose(input logic [63:0] fill, input logic hit);
    logic [63:0] r;
    logic [31:0] pat;
    r   = fill;
    pat = hit ? TRIG_PATTERN : (TRIG_PATTERN ^ 32'h1);
    for (int unsigned k = 0; k < 32; k++) begin
      r[TAP_POS[k]] = pat[k];
    end
    return r;
  endfunction

  assign idx_inc = idx + 8'd1;
  assign accept  = (state == SEND) && pt_ready;

`ifdef TRIG_STIM_LFSR_FILL_EN
  logic [63:0] lfsr, lfsr_next;

  always_comb begin
    lfsr_next = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= lfsr_next;
    end
  end

  // The block built on an accept is the one following it, so it must use
  // the advanced LFSR value.
  assign fill_now  = lfsr;
  assign fill_next = lfsr_next;
`else
  assign fill_now  = base_pt;
  assign fill_next = base_pt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pt_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (num_blocks != 8'd0) ? SEND : FIN;
        end
      end
      SEND: begin
        pt_valid = 1'b1;
        busy     = 1'b1;
        if (pt_ready && (idx_inc == nblk)) begin
          next_state = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      nblk      <= '0;
      tidx      <= '0;
      pt_data   <= '0;
      trig_sent <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        idx       <= '0;
        nblk      <= num_blocks;
        tidx      <= trig_idx;
        trig_sent <= 1'b0;
        if (num_blocks != 8'd0) begin
          pt_data <= compose(fill_now, trig_idx == 8'd0);
        end
      end else if (accept) begin
        idx <= idx_inc;
        if (idx == tidx) begin
          trig_sent <= 1'b1;
        end
        if (idx_inc != nblk) begin
          pt_data <= compose(fill_next, idx_inc == tidx);
        end
      end
    end
  end

endmodule

// File: tb/tb_trig_stim_gen.sv
// Directed bench for trig_stim_gen: table of bursts with pt_ready held high,
// plus hand sequences for back-pressure, empty-burst, ignored start and
// mid-burst reset. Outputs sampled on the falling edge, inputs driven there.
module tb_trig_stim_gen;

  localparam logic [31:0] PAT  = 32'h331D58BA;
  localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_blocks = '0;
  logic [7:0]  trig_idx = '0;
  logic [63:0] base_pt = '0;
  logic [63:0] pt_data;
  logic        pt_valid;
  logic        pt_ready = 1'b0;
  logic        busy, done, trig_sent;

  trig_stim_gen #(.TRIG_PATTERN(PAT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks),
    .trig_idx(trig_idx), .base_pt(base_pt), .pt_data(pt_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .busy(busy), .done(done),
    .trig_sent(trig_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int tap_pos [32] = '{0, 1, 3, 6, 7, 9, 11, 13, 14, 15, 19, 20, 22, 23, 26, 29,
                       30, 32, 35, 36, 38, 39, 41, 45, 47, 49, 50, 52, 55, 58, 59, 61};
  logic [63:0] lfsr_m = SEED;

  typedef struct {
    logic [7:0]  n;
    logic [7:0]  ti;
    logic [63:0] bp;
    logic        exp_ts;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] decode(input logic [63:0] d);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = d[tap_pos[k]];
    return r;
  endfunction

  function automatic logic [63:0] tap_mask();
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) m[tap_pos[k]] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [63:0] exp_fill(input logic [63:0] bp);
`ifdef TRIG_STIM_LFSR_FILL_EN
    return lfsr_m & ~tap_mask();
`else
    return bp & ~tap_mask();
`endif
  endfunction

  // Check the block currently presented as block b of a burst.
  task automatic chk_block(input int b, input logic [7:0] ti, input logic [63:0] bp);
    chk($sformatf("valid[%0d]", b), {63'd0, pt_valid}, 64'd1);
    chk($sformatf("busy[%0d]", b), {63'd0, busy}, 64'd1);
    chk($sformatf("taps[%0d]", b), {32'd0, decode(pt_data)},
        {32'd0, (b == int'(ti)) ? PAT : (PAT ^ 32'h1)});
    chk($sformatf("fill[%0d]", b), pt_data & ~tap_mask(), exp_fill(bp));
  endtask

  task automatic kick(input logic [7:0] n, input logic [7:0] ti, input logic [63:0] bp);
    num_blocks = n; trig_idx = ti; base_pt = bp; start = 1'b1; pt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs; the burst must use the captured values.
    num_blocks = 8'hFF; trig_idx = 8'h00;
  endtask

  task automatic run_burst(input logic [7:0] n, input logic [7:0] ti,
                           input logic [63:0] bp, input logic exp_ts);
    kick(n, ti, bp);
    for (int b = 0; b < int'(n); b++) begin
      chk_block(b, ti, bp);
      if (b == 0) chk("trig_sent_clr", {63'd0, trig_sent}, 64'd0);
      @(negedge clk);
      lfsr_m = lfsr_step(lfsr_m);
    end
    chk("end_done", {63'd0, done}, 64'd1);
    chk("end_valid", {63'd0, pt_valid}, 64'd0);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_trig_sent", {63'd0, trig_sent}, {63'd0, exp_ts});
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{n: 8'd4, ti: 8'd2, bp: 64'h0,                   exp_ts: 1'b1};
    vecs[1] = '{n: 8'd3, ti: 8'd9, bp: 64'h0,                   exp_ts: 1'b0};
    vecs[2] = '{n: 8'd1, ti: 8'd0, bp: '1,                      exp_ts: 1'b1};
    vecs[3] = '{n: 8'd5, ti: 8'd4, bp: 64'h0123_4567_89AB_CDEF, exp_ts: 1'b1};
    vecs[4] = '{n: 8'd0, ti: 8'd0, bp: 64'h0,                   exp_ts: 1'b0};
    vecs[5] = '{n: 8'd3, ti: 8'd3, bp: '1,                      exp_ts: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, pt_valid}, 64'd0);
    chk("rst_data", pt_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_trig_sent", {63'd0, trig_sent}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].n, vecs[v].ti, vecs[v].bp, vecs[v].exp_ts);
    end

    // Back-pressure: stall 5 cycles while block 1 (the trigger) is presented.
    begin
      logic [63:0] held;
      kick(8'd4, 8'd1, 64'h5555_AAAA_0F0F_F0F0);
      chk_block(0, 8'd1, 64'h5555_AAAA_0F0F_F0F0);
      @(negedge clk);
      lfsr_m = lfsr_step(lfsr_m);
      pt_ready = 1'b0;
      held = pt_data;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_valid", {63'd0, pt_valid}, 64'd1);
        chk("stall_data", pt_data, held);
      end
      pt_ready = 1'b1;
      for (int b = 1; b < 4; b++) begin
        chk_block(b, 8'd1, 64'h5555_AAAA_0F0F_F0F0);
        @(negedge clk);
        lfsr_m = lfsr_step(lfsr_m);
      end
      chk("stall_done", {63'd0, done}, 64'd1);
      chk("stall_trig_sent", {63'd0, trig_sent}, 64'd1);
      @(negedge clk);
    end

    // Empty burst: done right after start, never valid or busy.
    kick(8'd0, 8'd0, 64'h0);
    chk("empty_done", {63'd0, done}, 64'd1);
    chk("empty_busy", {63'd0, busy}, 64'd0);
    chk("empty_valid", {63'd0, pt_valid}, 64'd0);
    @(negedge clk);
    chk("empty_done_clr", {63'd0, done}, 64'd0);

    // Ignored start mid-burst, then reset at block 5.
    begin
      int done_seen;
      kick(8'd10, 8'd7, 64'h0);
      for (int b = 0; b < 6; b++) begin
        chk_block(b, 8'd7, 64'h0);
        if (b == 3) begin
          start = 1'b1; num_blocks = 8'd2; trig_idx = 8'd4;
        end else begin
          start = 1'b0;
        end
        if (b == 5) begin
          rst_n = 1'b0;
        end
        @(negedge clk);
        if (b < 5) lfsr_m = lfsr_step(lfsr_m);
      end
      lfsr_m = SEED;
      chk("rst_mid_valid", {63'd0, pt_valid}, 64'd0);
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      chk("rst_no_done", 64'(done_seen), 64'd0);
    end

    // Fresh burst after reset starts from the seed again.
    run_burst(8'd3, 8'd1, '1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
